// File: rtl/regfile_2r1w_spill_if.sv
// Bundle of the register file's bus signals: one write port, two read ports,
// the spill stream and the debug view of every register.
//   master : the datapath/control side that issues writes, reads and spills
//   slave  : the register file itself
interface regfile_2r1w_spill_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SELW  = 3
);
  // write port
  logic                   wr_en;
  logic [SELW-1:0]        wr_sel;
  logic [WIDTH-1:0]       wr_data;
  logic                   wr_ready;
  // read port A
  logic                   rd_en_a;
  logic [SELW-1:0]        rd_sel_a;
  logic [WIDTH-1:0]       rd_data_a;
  // read port B
  logic                   rd_en_b;
  logic [SELW-1:0]        rd_sel_b;
  logic [WIDTH-1:0]       rd_data_b;
  // spill stream
  logic                   spill_start;
  logic                   spill_valid;
  logic                   spill_ready;
  logic [SELW-1:0]        spill_idx;
  logic [WIDTH-1:0]       spill_data;
  logic                   spill_done;
  logic                   busy;
  // debug view, register i at [i*WIDTH +: WIDTH]
  logic [WIDTH*DEPTH-1:0] regs_flat;

  modport master (
    output wr_en, wr_sel, wr_data,
    output rd_en_a, rd_sel_a, rd_en_b, rd_sel_b,
    output spill_start, spill_ready,
    input  wr_ready, rd_data_a, rd_data_b,
    input  spill_valid, spill_idx, spill_data, spill_done, busy, regs_flat
  );

  modport slave (
    input  wr_en, wr_sel, wr_data,
    input  rd_en_a, rd_sel_a, rd_en_b, rd_sel_b,
    input  spill_start, spill_ready,
    output wr_ready, rd_data_a, rd_data_b,
    output spill_valid, spill_idx, spill_data, spill_done, busy, regs_flat
  );
endinterface

// File: rtl/regfile_2r1w_spill.sv
// Parametrised register file: one write port, two independent combinational
// read ports with write-through bypass, and a handshaked spill engine that
// streams every register out in index order (context save / debug dump).
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (clears registers, aborts a spill)
//   bus  - regfile_2r1w_spill_if.slave: write, read A/B, spill stream,
//          busy and the flat debug view regs_flat
module regfile_2r1w_spill #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SELW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_2r1w_spill_if.slave  bus
);

  // DEPTH widened by one bit so the range check works when 2**SELW == DEPTH
  localparam logic [SELW:0]   DEPTH_W  = (SELW+1)'(DEPTH);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPILL = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [SELW-1:0]   idx_reg, idx_next;
  logic              done_reg, done_next;
  logic [WIDTH-1:0]  regs_reg [DEPTH];

  logic              wr_accept;
  logic [WIDTH-1:0]  spill_word;

  // Writes only land in IDLE and only for existing registers; anything else
  // is dropped without side effects.
  assign wr_accept = bus.wr_en && (state_reg == ST_IDLE) &&
                     ({1'b0, bus.wr_sel} < DEPTH_W);

  // ---------------------------------------------------------------- storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.wr_sel == SELW'(i)) begin
          regs_reg[i] <= bus.wr_data;
        end
      end
    end
  end

  // Debug view shows stored contents only, never the bypass value.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign bus.regs_flat[gi*WIDTH +: WIDTH] = regs_reg[gi];
    end
  endgenerate

  // ------------------------------------------------------------- read ports
  // Both ports share one structure; index 0 is port A, index 1 is port B.
  logic             rd_en   [2];
  logic [SELW-1:0]  rd_sel  [2];
  logic [WIDTH-1:0] rd_data [2];

  assign rd_en[0]  = bus.rd_en_a;
  assign rd_sel[0] = bus.rd_sel_a;
  assign rd_en[1]  = bus.rd_en_b;
  assign rd_sel[1] = bus.rd_sel_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = '0;
        if (rd_en[gi]) begin
          // wr_accept already implies wr_sel is in range, so an
          // out-of-range read can never pick up the bypass value.
          if (wr_accept && (rd_sel[gi] == bus.wr_sel)) begin
            rd_data[gi] = bus.wr_data;
          end else begin
            for (int i = 0; i < DEPTH; i++) begin
              if (rd_sel[gi] == SELW'(i)) begin
                rd_data[gi] = regs_reg[i];
              end
            end
          end
        end
      end
    end
  endgenerate

  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];

  // ------------------------------------------------------------ spill FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.spill_start) begin
          state_next = ST_SPILL;
          idx_next   = '0;
        end
      end
      ST_SPILL: begin
        if (bus.spill_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_IDLE;
            idx_next   = '0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + SELW'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Writes are blocked during a spill, so this word is stable while stalled.
  always_comb begin
    spill_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_reg == SELW'(i)) begin
        spill_word = regs_reg[i];
      end
    end
  end

  assign bus.spill_valid = (state_reg == ST_SPILL);
  assign bus.busy        = (state_reg == ST_SPILL);
  assign bus.wr_ready    = (state_reg == ST_IDLE);
  assign bus.spill_idx   = idx_reg;
  assign bus.spill_data  = spill_word;
  assign bus.spill_done  = done_reg;

endmodule

// File: tb/tb_regfile_2r1w_spill.sv
// Directed bench for regfile_2r1w_spill: an 8-deep default instance and a
// 5-deep instance sharing clock and reset.
module tb_regfile_2r1w_spill;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_2r1w_spill_if #(.WIDTH(8), .DEPTH(8), .SELW(3)) if8 ();
  regfile_2r1w_spill_if #(.WIDTH(8), .DEPTH(5), .SELW(3)) if5 ();

  regfile_2r1w_spill #(.WIDTH(8), .DEPTH(8), .SELW(3)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  regfile_2r1w_spill #(.WIDTH(8), .DEPTH(5), .SELW(3)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (if5.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr8(input logic [2:0] sel, input logic [7:0] data);
    if8.wr_en = 1'b1; if8.wr_sel = sel; if8.wr_data = data;
    cyc();
    if8.wr_en = 1'b0;
  endtask

  task automatic wr5(input logic [2:0] sel, input logic [7:0] data);
    if5.wr_en = 1'b1; if5.wr_sel = sel; if5.wr_data = data;
    cyc();
    if5.wr_en = 1'b0;
  endtask

  initial begin
    int k;
    int guard;
    logic rdy;

    if8.wr_en = 0; if8.wr_sel = 0; if8.wr_data = 0;
    if8.rd_en_a = 0; if8.rd_sel_a = 0; if8.rd_en_b = 0; if8.rd_sel_b = 0;
    if8.spill_start = 0; if8.spill_ready = 0;
    if5.wr_en = 0; if5.wr_sel = 0; if5.wr_data = 0;
    if5.rd_en_a = 0; if5.rd_sel_a = 0; if5.rd_en_b = 0; if5.rd_sel_b = 0;
    if5.spill_start = 0; if5.spill_ready = 0;

    // ---- reset state
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_busy",        if8.busy,        0);
    chk("rst_spill_valid", if8.spill_valid, 0);
    chk("rst_spill_done",  if8.spill_done,  0);
    chk("rst_wr_ready",    if8.wr_ready,    1);
    chk("rst_regs_flat",   if8.regs_flat,   0);

    // ---- basic write / dual read
    wr8(3'd3, 8'hA5);
    wr8(3'd7, 8'h3C);
    if8.rd_en_a = 1; if8.rd_sel_a = 3;
    if8.rd_en_b = 1; if8.rd_sel_b = 7;
    #1;
    chk("rd_a_r3",      if8.rd_data_a, 8'hA5);
    chk("rd_b_r7",      if8.rd_data_b, 8'h3C);
    chk("flat_r3",      if8.regs_flat[31:24], 8'hA5);
    chk("flat_r7",      if8.regs_flat[63:56], 8'h3C);
    if8.rd_en_a = 0;
    #1;
    chk("rd_a_disabled", if8.rd_data_a, 8'h00);

    // ---- bypass
    wr8(3'd2, 8'h11);
    if8.wr_en = 1; if8.wr_sel = 2; if8.wr_data = 8'h99;
    if8.rd_en_a = 1; if8.rd_sel_a = 2;
    if8.rd_en_b = 1; if8.rd_sel_b = 2;
    #1;
    chk("byp_a",       if8.rd_data_a, 8'h99);
    chk("byp_b",       if8.rd_data_b, 8'h99);
    chk("byp_flat_r2", if8.regs_flat[23:16], 8'h11);
    cyc();
    if8.wr_en = 0;
    #1;
    chk("stored_a_r2", if8.rd_data_a, 8'h99);
    chk("stored_b_r2", if8.rd_data_b, 8'h99);

    // ---- full-throughput spill; r7 written in the start cycle
    for (int i = 0; i < 7; i++) wr8(3'(i), 8'(8'h10 + i));
    if8.wr_en = 1; if8.wr_sel = 7; if8.wr_data = 8'h17;
    if8.spill_start = 1; if8.spill_ready = 1;
    cyc();
    if8.wr_en = 0; if8.spill_start = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sp_valid_%0d", i), if8.spill_valid, 1);
      chk($sformatf("sp_idx_%0d", i),   if8.spill_idx, 64'(i));
      chk($sformatf("sp_data_%0d", i),  if8.spill_data, 64'(8'h10 + i));
      chk($sformatf("sp_done_lo_%0d", i), if8.spill_done, 0);
      cyc();
    end
    chk("sp_done_pulse", if8.spill_done, 1);
    chk("sp_busy_end",   if8.busy, 0);
    chk("sp_valid_end",  if8.spill_valid, 0);
    cyc();
    chk("sp_done_once",  if8.spill_done, 0);

    // ---- backpressure with a write held during the spill
    if8.spill_ready = 0; if8.spill_start = 1;
    cyc();
    if8.spill_start = 0;
    if8.wr_en = 1; if8.wr_sel = 0; if8.wr_data = 8'hFF;
    k = 0; guard = 0;
    while (k < 8 && guard < 40) begin
      rdy = guard[0];
      if8.spill_ready = rdy;
      #1;
      chk($sformatf("bp_idx_c%0d", guard),  if8.spill_idx, 64'(k));
      chk($sformatf("bp_data_c%0d", guard), if8.spill_data, 64'(8'h10 + k));
      chk($sformatf("bp_wr_ready_c%0d", guard), if8.wr_ready, 0);
      cyc();
      if (rdy) k++;
      guard++;
    end
    if8.wr_en = 0; if8.spill_ready = 0;
    chk("bp_beats_seen", 64'(k), 8);
    chk("bp_done_pulse", if8.spill_done, 1);
    if8.rd_en_a = 1; if8.rd_sel_a = 0;
    #1;
    chk("bp_r0_unchanged", if8.rd_data_a, 8'h10);
    cyc();

    // ---- reset in the middle of a spill
    if8.spill_start = 1; if8.spill_ready = 1;
    cyc();
    if8.spill_start = 0;
    for (int i = 0; i < 4; i++) cyc();
    chk("mid_idx_before_rst", if8.spill_idx, 4);
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_busy",  if8.busy, 0);
    chk("mid_valid", if8.spill_valid, 0);
    chk("mid_done",  if8.spill_done, 0);
    chk("mid_flat",  if8.regs_flat, 0);
    if8.rd_sel_a = 5;
    #1;
    chk("mid_rd_r5", if8.rd_data_a, 0);
    cyc();
    chk("mid_done_next", if8.spill_done, 0);
    if8.spill_ready = 0;

    // ---- DEPTH=5 instance
    wr5(3'd6, 8'hEE);
    chk("d5_oor_write_dropped", if5.regs_flat, 0);
    if5.rd_en_a = 1; if5.rd_sel_a = 6;
    if5.wr_en = 1; if5.wr_sel = 6; if5.wr_data = 8'h77;
    #1;
    chk("d5_oor_read_no_bypass", if5.rd_data_a, 0);
    if5.wr_en = 0;
    for (int i = 0; i < 5; i++) wr5(3'(i), 8'(8'h20 + i));
    chk("d5_flat_r4", if5.regs_flat[39:32], 8'h24);
    if5.spill_start = 1; if5.spill_ready = 1;
    cyc();
    if5.spill_start = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("d5_sp_idx_%0d", i),  if5.spill_idx, 64'(i));
      chk($sformatf("d5_sp_data_%0d", i), if5.spill_data, 64'(8'h20 + i));
      cyc();
    end
    chk("d5_sp_done",  if5.spill_done, 1);
    chk("d5_sp_valid", if5.spill_valid, 0);
    if5.spill_ready = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
